// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc sequencer: opcodes, ULA op codes, instruction fields, FSM states.
package nrisc_pkg;

    localparam int unsigned INSTR_W  = 8;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned REG_AW   = 2;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned OFF_W    = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b100;
    localparam logic [OP_W-1:0] OP_JMP  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOP  = 3'b110;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 5;
    localparam int unsigned RA_MSB  = 4;
    localparam int unsigned RA_LSB  = 3;
    localparam int unsigned RB_MSB  = 2;
    localparam int unsigned RB_LSB  = 1;
    localparam int unsigned OFF_MSB = 4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_PCUPD,
        ST_HALT
    } state_t;

    // Data ops occupy the lower half of the opcode space.
    function automatic logic is_data_op(input logic [OP_W-1:0] op);
        return ~op[OP_W-1];
    endfunction

endpackage

// File: rtl/ula_operand_mux.sv
// Chooses ULA operands/op for the state being entered: register data in EXEC, PC step in PCUPD.
module ula_operand_mux
    import nrisc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  state_t                state,
    input  logic [W-1:0]          pc,
    input  logic [W-1:0]          rdata_a,
    input  logic [W-1:0]          rdata_b,
    input  logic [OFF_W-1:0]      off5,
    input  logic                  taken,
    input  logic [ALU_OP_W-1:0]   data_op,
    output logic [W-1:0]          a_c,
    output logic [W-1:0]          b_c,
    output logic [ALU_OP_W-1:0]   op_c
);

    logic [W-1:0] off_sext;

    assign off_sext = {{(W-OFF_W){off5[OFF_W-1]}}, off5};

    always_comb begin
        a_c  = '0;
        b_c  = '0;
        op_c = ALU_ADD;
        case (state)
            ST_EXEC: begin
                a_c  = rdata_a;
                b_c  = rdata_b;
                op_c = data_op;
            end
            ST_PCUPD: begin
                a_c  = pc;
                b_c  = taken ? off_sext : W'(1);
                op_c = ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nrisc_seq_ctrl.sv
// Multi-cycle control FSM for the 8-bit nRisc core; owns the PC and time-shares the ULA.
// Define NRISC_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
module nrisc_seq_ctrl
    import nrisc_pkg::*;
#(
    parameter int unsigned   W        = 8,
    parameter logic [W-1:0]  PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [W-1:0]        imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [REG_AW-1:0]   rf_ra,
    output logic [REG_AW-1:0]   rf_rb,
    input  logic [W-1:0]        rf_rdata_a,
    input  logic [W-1:0]        rf_rdata_b,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_wa,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [W-1:0]        alu_result,
    input  logic                alu_zero,
`ifdef NRISC_PERF_CNT_EN
    output logic                halted,
    output logic [15:0]         cyc_cnt,
    output logic [15:0]         ret_cnt
`else
    output logic                halted
`endif
);

    state_t               state;
    state_t               next_state;
    logic [W-1:0]         pc;
    logic [INSTR_W-1:0]   instr;
    logic                 zflag;
    logic [OP_W-1:0]      op;
    logic                 taken;
    logic                 fetch_done;
    logic [W-1:0]         mux_a;
    logic [W-1:0]         mux_b;
    logic [ALU_OP_W-1:0]  mux_op;

    assign op         = instr[OP_MSB:OP_LSB];
    assign taken      = (op == OP_JMP) || ((op == OP_BEQ) && zflag);
    assign fetch_done = (state == ST_FETCH) && imem_req && imem_ack;

    assign imem_addr = pc;
    assign rf_ra     = instr[RA_MSB:RA_LSB];
    assign rf_rb     = instr[RB_MSB:RB_LSB];
    assign rf_wa     = instr[RA_MSB:RA_LSB];

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH:  if (fetch_done) next_state = ST_DECODE;
            ST_DECODE: begin
                if (is_data_op(op))     next_state = ST_EXEC;
                else if (op == OP_HALT) next_state = ST_HALT;
                else                    next_state = ST_PCUPD;
            end
            ST_EXEC:   next_state = ST_PCUPD;
            ST_PCUPD:  next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_FETCH;
        endcase
    end

    // Operands are computed for the state being entered so the registered outputs line up with it.
    ula_operand_mux #(.W(W)) u_mux (
        .state   (next_state),
        .pc      (pc),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .off5    (instr[OFF_MSB:0]),
        .taken   (taken),
        .data_op (op[ALU_OP_W-1:0]),
        .a_c     (mux_a),
        .b_c     (mux_b),
        .op_c    (mux_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            pc       <= PC_RESET;
            instr    <= '0;
            zflag    <= 1'b0;
            imem_req <= 1'b0;
            rf_we    <= 1'b0;
            halted   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= ALU_ADD;
        end else begin
            state    <= next_state;
            imem_req <= (next_state == ST_FETCH);
            rf_we    <= (next_state == ST_EXEC);
            halted   <= (next_state == ST_HALT);
            alu_a    <= mux_a;
            alu_b    <= mux_b;
            alu_op   <= mux_op;
            if (fetch_done)          instr <= imem_rdata;
            if (state == ST_EXEC)    zflag <= alu_zero;
            if (state == ST_PCUPD)   pc    <= alu_result;
        end
    end

`ifdef NRISC_PERF_CNT_EN
    // Cycle and retire counters; both stop once the core halts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != ST_HALT)  cyc_cnt <= cyc_cnt + 16'(1);
            if (state == ST_PCUPD) ret_cnt <= ret_cnt + 16'(1);
        end
    end
`endif

endmodule
